// File: rtl/controlador_display.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits
// sharing one decoder, with a double-buffered load, guard time and zero blanking.
module controlador_display #(
    parameter int NUM_DIGITOS   = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int TEMPO_GUARDA  = 500,
    parameter int APAGAR_ZEROS  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     carregar,
    input  logic [4*NUM_DIGITOS-1:0] valor,
    output logic                     pronto,
    output logic [3:0]               entrada_decod,
    output logic [NUM_DIGITOS-1:0]   digito_sel,
    output logic                     erro_bcd
);
    localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam int CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int VW = 4 * NUM_DIGITOS;

    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [VW-1:0] sombra;
    logic [VW-1:0] exibido;
    logic          pendente;

    logic          fim_slot;
    logic          fim_quadro;
    logic          guarda;
    logic          valor_invalido;
    logic          apagar_lz;
    logic          zeros_acima;
    logic [3:0]    nibble;

    assign fim_slot   = (cnt == CW'(DIV_VARREDURA - 1));
    assign fim_quadro = fim_slot && (idx == IW'(NUM_DIGITOS - 1));
    assign guarda     = (cnt < CW'(TEMPO_GUARDA));
    assign nibble     = exibido[{idx, 2'b00} +: 4];
    assign pronto     = !pendente;

    always_comb begin
        valor_invalido = 1'b0;
        for (int i = 0; i < NUM_DIGITOS; i++)
            if (valor[4*i +: 4] > 4'd9) valor_invalido = 1'b1;
    end

    // Walk from the top digit down; a digit is a leading zero when it and all
    // higher digits are 4'h0. Invalid nibbles are nonzero and stop the run.
    always_comb begin
        apagar_lz   = 1'b0;
        zeros_acima = 1'b1;
        for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
            zeros_acima = zeros_acima && (exibido[4*i +: 4] == 4'h0);
            if (IW'(i) == idx)
                apagar_lz = zeros_acima && (i != 0) && (APAGAR_ZEROS != 0);
        end
    end

    always_comb begin
        entrada_decod = 4'hF;
        digito_sel    = '1;
        if (!guarda && !apagar_lz) begin
            entrada_decod = (nibble > 4'd9) ? 4'hF : nibble;
            digito_sel    = ~(NUM_DIGITOS'(1) << idx);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            cnt      <= '0;
            sombra   <= '0;
            exibido  <= '0;
            pendente <= 1'b0;
            erro_bcd <= 1'b0;
        end else begin
            if (fim_slot) begin
                cnt <= '0;
                idx <= (idx == IW'(NUM_DIGITOS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Commit only at the frame boundary so no frame mixes old and new digits.
            if (pendente) begin
                if (fim_quadro) begin
                    exibido  <= sombra;
                    pendente <= 1'b0;
                end
            end else if (carregar) begin
                sombra   <= valor;
                pendente <= 1'b1;
                erro_bcd <= valor_invalido;
            end
        end
    end
endmodule

// File: tb/tb_controlador_display.sv
// Directed bench for controlador_display: table of per-step vectors plus
// hand sequences for mid-frame reset and a held load request.
module tb_controlador_display;
    logic        clock;
    logic        reset;
    logic        carregar;
    logic [15:0] valor;
    logic        pronto;
    logic [3:0]  entrada_decod;
    logic [3:0]  digito_sel;
    logic        erro_bcd;

    int n_chk  = 0;
    int n_fail = 0;

    controlador_display #(
        .NUM_DIGITOS  (4),
        .DIV_VARREDURA(4),
        .TEMPO_GUARDA (1),
        .APAGAR_ZEROS (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .carregar     (carregar),
        .valor        (valor),
        .pronto       (pronto),
        .entrada_decod(entrada_decod),
        .digito_sel   (digito_sel),
        .erro_bcd     (erro_bcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          adv;
        logic        car;
        logic [15:0] val;
        logic        e_pronto;
        logic [3:0]  e_sel;
        logic [3:0]  e_dec;
        logic        e_err;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t v(int adv, logic car, logic [15:0] val,
                               logic ep, logic [3:0] es, logic [3:0] ed, logic ee);
        vec_t r;
        r.adv = adv; r.car = car; r.val = val;
        r.e_pronto = ep; r.e_sel = es; r.e_dec = ed; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string nome, input int n, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nome, n, got, exp);
        end
    endtask

    task automatic chk_all(input string nome, input int n, input logic ep,
                           input logic [3:0] es, input logic [3:0] ed, input logic ee);
        chk({nome, ".pronto"}, n, {3'b000, pronto}, {3'b000, ep});
        chk({nome, ".sel"},    n, digito_sel, es);
        chk({nome, ".dec"},    n, entrada_decod, ed);
        chk({nome, ".erro"},   n, {3'b000, erro_bcd}, {3'b000, ee});
    endtask

    task automatic avanca(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Leaves the bench at a negedge with the DUT at cnt=0, idx=0 (position 0).
    task automatic reinicia();
        @(negedge clock);
        carregar = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        carregar = 1'b0;
        valor    = 16'h0000;
        #2;
        chk_all("em_reset", 0, 1'b1, 4'b1111, 4'hF, 1'b0);

        // Positions p count edges since reset release; frame = 16 edges.
        tab.push_back(v( 0, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p0 guard
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'h0, 0)); // p1 digit0 = 0
        tab.push_back(v( 1, 1, 16'h1234, 0, 4'b1110, 4'h0, 0)); // p2 captured, old shown
        tab.push_back(v( 3, 0, 16'h0000, 0, 4'b1111, 4'hF, 0)); // p5 zero blanked
        tab.push_back(v( 4, 0, 16'h0000, 0, 4'b1111, 4'hF, 0)); // p9
        tab.push_back(v( 4, 0, 16'h0000, 0, 4'b1111, 4'hF, 0)); // p13
        tab.push_back(v( 3, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p16 committed
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'h4, 0)); // p17
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'h3, 0)); // p21
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1011, 4'h2, 0)); // p25
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b0111, 4'h1, 0)); // p29
        tab.push_back(v( 1, 1, 16'h0050, 0, 4'b0111, 4'h1, 0)); // p30
        tab.push_back(v( 1, 0, 16'h0000, 0, 4'b0111, 4'h1, 0)); // p31
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p32
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'h0, 0)); // p33 digit0 never blanked
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'h5, 0)); // p37
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p41 slot2 blanked
        tab.push_back(v( 1, 1, 16'h1111, 0, 4'b1111, 4'hF, 0)); // p42 capture 1111
        tab.push_back(v( 1, 0, 16'h0000, 0, 4'b1111, 4'hF, 0)); // p43
        tab.push_back(v( 1, 1, 16'h2222, 0, 4'b1111, 4'hF, 0)); // p44 ignored
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p48
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'h1, 0)); // p49
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'h1, 0)); // p53
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1011, 4'h1, 0)); // p57
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b0111, 4'h1, 0)); // p61
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1110, 4'h1, 0)); // p65 still 1111
        tab.push_back(v( 1, 1, 16'h00A3, 0, 4'b1110, 4'h1, 1)); // p66 invalid captured
        tab.push_back(v(14, 0, 16'h0000, 1, 4'b1111, 4'hF, 1)); // p80
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'h3, 1)); // p81
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1101, 4'hF, 1)); // p85 invalid nibble lit
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1111, 4'hF, 1)); // p89
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1111, 4'hF, 1)); // p93
        tab.push_back(v( 1, 1, 16'h0003, 0, 4'b1111, 4'hF, 0)); // p94 erro clears
        tab.push_back(v( 2, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p96
        tab.push_back(v( 1, 0, 16'h0000, 1, 4'b1110, 4'h3, 0)); // p97
        tab.push_back(v( 4, 0, 16'h0000, 1, 4'b1111, 4'hF, 0)); // p101

        reinicia();
        foreach (tab[i]) begin
            carregar = tab[i].car;
            valor    = tab[i].val;
            avanca(tab[i].adv);
            chk_all("tab", i, tab[i].e_pronto, tab[i].e_sel, tab[i].e_dec, tab[i].e_err);
        end
        carregar = 1'b0;

        // Asynchronous reset in the middle of a digit-2 active phase with a load pending.
        reinicia();
        carregar = 1'b1; valor = 16'h9876;
        avanca(1);
        carregar = 1'b0;
        avanca(16);                                              // p17
        carregar = 1'b1; valor = 16'h1357;
        avanca(1);                                               // p18, pending
        carregar = 1'b0;
        avanca(7);                                               // p25
        chk_all("rst_antes", 0, 1'b0, 4'b1011, 4'h8, 1'b0);
        #2 reset = 1'b1;
        #1 chk_all("rst_meio", 0, 1'b1, 4'b1111, 4'hF, 1'b0);
        @(negedge clock);
        reset = 1'b0;                                            // p0
        avanca(1);
        chk_all("rst_pos", 1, 1'b1, 4'b1110, 4'h0, 1'b0);
        avanca(16);                                              // p17
        chk_all("rst_pos", 17, 1'b1, 4'b1110, 4'h0, 1'b0);
        avanca(4);                                               // p21
        chk_all("rst_pos", 21, 1'b1, 4'b1111, 4'hF, 1'b0);

        // carregar held high: one capture per pronto window.
        reinicia();
        carregar = 1'b1; valor = 16'h0007;
        avanca(1);
        chk_all("segura", 1, 1'b0, 4'b1110, 4'h0, 1'b0);
        avanca(15);                                              // p16
        chk_all("segura", 16, 1'b1, 4'b1111, 4'hF, 1'b0);
        valor = 16'h0009;
        avanca(1);                                               // p17
        chk_all("segura", 17, 1'b0, 4'b1110, 4'h7, 1'b0);
        carregar = 1'b0;
        avanca(16);                                              // p33
        chk_all("segura", 33, 1'b1, 4'b1110, 4'h9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/controlador_display.md
Name: controlador_display

Overview:
- Time-multiplexed scan controller for a bank of NUM_DIGITOS common-anode 7-segment digits that share one `decodificador`.
- Takes a packed BCD value through a load handshake and double-buffers it.
- Each display slot it drives the shared decoder's 4-bit input and one active-low digit select.
- Adds anti-ghosting guard time, leading-zero blanking and invalid-BCD flagging.
- Sits between counter/datapath logic and the board display pins.

Parameters:
NUM_DIGITOS, 4, number of digits scanned; legal range 2..8
DIV_VARREDURA, 50000, clock cycles per digit slot; must be > TEMPO_GUARDA
TEMPO_GUARDA, 500, cycles at the start of each slot with all digits off; legal range 0..DIV_VARREDURA-1
APAGAR_ZEROS, 1, 1 = leading-zero blanking enabled; 0 = all digits always shown

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
carregar  input  1  load request; sampled on the rising edge
valor  input  4*NUM_DIGITOS  packed BCD; digit i = valor[4i+3:4i], digit 0 = least significant
pronto  output  1  high when a load will be accepted (= not pendente)
entrada_decod  output  4  code to the shared decoder; 4'hF = blank
digito_sel  output  NUM_DIGITOS  active-low one-hot digit enable; all ones = none lit
erro_bcd  output  1  high if the last captured value had any nibble > 9

Behaviour:
- Registers:
  - idx: digit index, 0..NUM_DIGITOS-1
  - cnt: slot counter, 0..DIV_VARREDURA-1
  - sombra: shadow value
  - exibido: displayed value
  - pendente: shadow holds an uncommitted load
  - erro_bcd
- Reset (asynchronous, takes effect immediately, including mid-frame or mid-handshake):
  - idx=0, cnt=0, sombra=0, exibido=0, pendente=0, erro_bcd=0.
  - Outputs during and right after reset: pronto=1, digito_sel=all ones, entrada_decod=4'hF.
- Scan:
  - cnt increments every cycle.
  - At cnt=DIV_VARREDURA-1, cnt wraps to 0 and idx advances, wrapping NUM_DIGITOS-1 -> 0.
  - One frame = NUM_DIGITOS*DIV_VARREDURA cycles.
- Slot phases:
  - GUARDA (cnt < TEMPO_GUARDA): digito_sel=all ones, entrada_decod=4'hF.
  - ATIVO (cnt >= TEMPO_GUARDA): entrada_decod=nibble idx of exibido; digito_sel bit idx=0, all other bits 1.
  - Both outputs are a direct function of the registered idx/cnt/exibido, with no additional pipeline stage.
- Blanking rules, applied in ATIVO:
  - A nibble > 9 is output as 4'hF.
  - Leading zeros (APAGAR_ZEROS=1): for idx>0, if nibble idx and every higher nibble of exibido are 4'h0, then entrada_decod=4'hF and digito_sel stays all ones for the whole slot.
  - Digit 0 is never leading-zero blanked.
  - An invalid nibble counts as nonzero for the leading-zero rule.
- Load handshake:
  - If carregar=1 and pendente=0 on an edge: sombra<=valor, pendente<=1, and erro_bcd<=1 if any nibble > 9, else 0.
  - If carregar=1 while pendente=1: ignored; no state change.
  - The requester must see pronto=1 before a load counts.
- Commit:
  - On the last cycle of a frame (idx=NUM_DIGITOS-1, cnt=DIV_VARREDURA-1) with pendente=1: exibido<=sombra and pendente<=0.
  - The new value therefore appears starting at digit 0 of the next frame; no frame ever shows mixed old/new digits.
- Simultaneous events on that last frame cycle:
  - pendente=1: commit happens and any carregar is ignored (pronto was 0).
  - pendente=0 and carregar=1: capture only; commit happens at the end of the following frame.
- carregar held high: one capture per pronto window; after the next commit a further capture occurs if carregar is still high.

Test Plan:
All scenarios use NUM_DIGITOS=4, DIV_VARREDURA=4, TEMPO_GUARDA=1, APAGAR_ZEROS=1; cycle 0 is the first edge after reset release.
1. Reset state -> pronto=1, digito_sel=4'b1111, entrada_decod=F at cnt=0; at cnt=1..3 digito_sel=4'b1110, entrada_decod=0; slots 1..3 all-ones select (zeros blanked).
2. carregar=1, valor=16'h1234 in frame 0 -> pronto=0 the next cycle; display still shows 0 for the rest of frame 0; frame 1 active phases show digits 0..3 = 4,3,2,1 with selects 1110,1101,1011,0111; pronto=1 from start of frame 1.
3. Load 16'h0050 -> digit0 shows 0, digit1 shows 5, slots 2 and 3 have digito_sel=4'b1111 and entrada_decod=F.
4. Load 16'h1111, then 16'h2222 two cycles later in the same frame -> second load ignored; 1111 displayed; 2222 never appears.
5. Load 16'h00A3 -> erro_bcd=1; digit0 shows 3; digit1 is active with entrada_decod=F (invalid); digits 2,3 blanked. Then load 16'h0003 -> erro_bcd=0 on capture.
6. Assert reset in the middle of a digit2 active phase with pendente=1 -> same cycle: digito_sel=all ones, entrada_decod=F, pronto=1; after release, the display shows the digit-0 value 0 (exibido reset to 0) and the pending load is lost.
